farm_vehicle_detector: RTL and testbench

//  Producer side of the farm-road request line `c` read by the traffic light controller.

---
 rtl/farm_vehicle_detector.sv | 120 ++++++++++++
 tb/tb_farm_vehicle_detector.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/farm_vehicle_detector.sv
// rtl/farm_vehicle_detector.sv - farm-road loop sensor sync/debounce and vehicle request latch for the light controller
module farm_vehicle_detector #(
    parameter int DEB_CYCLES = 3,
    parameter int MAX_WAIT   = 80,
    parameter int WAIT_W     = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_raw,
    input  logic             FG,
    input  logic             FY,
    output logic             c,
    output logic             pend,
    output logic             served,
    output logic [CNT_W-1:0] veh_cnt,
    output logic             stuck
);
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, REQ, SERVE, CLEAR} state_t;

    state_t            state;
    logic              s_meta;
    logic              s_sync;
    logic              det_level;
    logic [DEB_W-1:0]  deb_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              det_rise;

    assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    assign det_rise = s_sync && !det_level && (deb_cnt == DEB_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_meta    <= 1'b0;
            s_sync    <= 1'b0;
            det_level <= 1'b0;
            deb_cnt   <= '0;
            wait_cnt  <= '0;
            veh_cnt   <= '0;
            state     <= IDLE;
            c         <= 1'b0;
            pend      <= 1'b0;
            served    <= 1'b0;
            stuck     <= 1'b0;
        end else begin
            s_meta <= sensor_raw;
            s_sync <= s_meta;

            // Symmetric filter: the level only moves after DEB_CYCLES disagreeing samples in a row.
            if (s_sync != det_level) begin
                if (deb_cnt == DEB_LAST) begin
                    det_level <= s_sync;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end

            if (det_rise && (veh_cnt != '1))
                veh_cnt <= veh_cnt + 1'b1;

            served <= 1'b0;

            case (state)
                IDLE: begin
                    if (det_level) begin
                        state <= REQ;
                        c     <= 1'b1;
                        pend  <= 1'b1;
                    end
                end
                REQ: begin
                    // FG together with FY is illegal and ignored while still waiting.
                    if (FG && !FY) begin
                        state    <= SERVE;
                        wait_cnt <= '0;
                        pend     <= 1'b0;
                        c        <= det_level;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == WAIT_MAX)
                            stuck <= 1'b1;
                    end
                end
                SERVE: begin
                    if (FY) begin
                        state  <= CLEAR;
                        c      <= 1'b0;
                        served <= 1'b1;
                    end else begin
                        c <= det_level;
                    end
                end
                CLEAR: begin
                    if (!FY) begin
                        if (det_level) begin
                            state <= REQ;
                            c     <= 1'b1;
                            pend  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    c     <= 1'b0;
                    pend  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_farm_vehicle_detector.sv
// tb/tb_farm_vehicle_detector.sv - randomized and directed checks of farm_vehicle_detector against a behavioural model
module tb_farm_vehicle_detector;
    localparam int DEB  = 3;
    localparam int MAXW = 80;
    localparam int P_IDLE = 0, P_REQ = 1, P_SERVE = 2, P_CLEAR = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sensor_raw = 1'b0;
    logic FG = 1'b0;
    logic FY = 1'b0;
    logic c, pend, served, stuck;
    logic [7:0] veh_cnt;
    logic c4, pend4, served4, stuck4;
    logic [3:0] veh_cnt4;

    int errors = 0;
    int checks = 0;

    bit raw_hist[$];
    int m_phase, m_wait, m_veh, m_veh4;
    bit m_det, m_c, m_pend, m_served, m_stuck;

    always #5 clk = ~clk;

    farm_vehicle_detector dut (
        .clk(clk), .rst_n(rst_n), .sensor_raw(sensor_raw), .FG(FG), .FY(FY),
        .c(c), .pend(pend), .served(served), .veh_cnt(veh_cnt), .stuck(stuck)
    );

    farm_vehicle_detector #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sensor_raw(sensor_raw), .FG(FG), .FY(FY),
        .c(c4), .pend(pend4), .served(served4), .veh_cnt(veh_cnt4), .stuck(stuck4)
    );

    // Reference: the debounced level flips once the last DEB synchronised samples
    // (raw values from 2..DEB+1 edges ago) all disagree with it.
    function automatic void model_step();
        bit old_det, flip;
        if (!rst_n) begin
            raw_hist = {};
            for (int i = 0; i < DEB + 2; i++) raw_hist.push_back(1'b0);
            m_phase = P_IDLE; m_wait = 0; m_veh = 0; m_veh4 = 0;
            m_det = 0; m_c = 0; m_pend = 0; m_served = 0; m_stuck = 0;
            return;
        end
        raw_hist.push_front(sensor_raw);
        void'(raw_hist.pop_back());
        old_det = m_det;
        flip = 1'b1;
        for (int i = 2; i < DEB + 2; i++)
            if (raw_hist[i] == old_det) flip = 1'b0;
        if (flip) begin
            m_det = !old_det;
            if (!old_det) begin
                if (m_veh < 255) m_veh++;
                if (m_veh4 < 15) m_veh4++;
            end
        end
        m_served = 0;
        case (m_phase)
            P_IDLE:  if (old_det) begin m_phase = P_REQ; m_wait = 0; end
            P_REQ: begin
                if (FG && !FY) begin
                    m_phase = P_SERVE;
                    m_wait = 0;
                end else begin
                    if (m_wait < MAXW) m_wait++;
                    if (m_wait == MAXW) m_stuck = 1;
                end
            end
            P_SERVE: if (FY) begin m_phase = P_CLEAR; m_served = 1; end
            default: if (!FY) m_phase = old_det ? P_REQ : P_IDLE;
        endcase
        m_pend = (m_phase == P_REQ);
        m_c = (m_phase == P_REQ) ? 1'b1 : (m_phase == P_SERVE) ? old_det : 1'b0;
    endfunction

    function automatic logic [19:0] obs();
        return {c, pend, served, stuck, veh_cnt, c4, pend4, served4, stuck4, veh_cnt4};
    endfunction

    function automatic logic [19:0] exp_vec();
        return {m_c, m_pend, m_served, m_stuck, 8'(m_veh), m_c, m_pend, m_served, m_stuck, 4'(m_veh4)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sensor_raw = 1'b0; FG = 1'b0; FY = 1'b0;
        do_reset();
        checks++;
        if (obs() !== 20'h0) begin
            errors++;
            $display("FAIL reset: got %h want 00000", obs());
        end
    endtask

    task automatic test_glitch();
        sensor_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == DEB - 1) sensor_raw = 1'b0;
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL glitch cyc %0d: got %h want %h", i, obs(), exp_vec());
            end
        end
        checks++;
        if ({c, pend, veh_cnt} !== 10'h0) begin
            errors++;
            $display("FAIL glitch_quiet: got c=%b pend=%b veh=%0d want 0 0 0", c, pend, veh_cnt);
        end
    endtask

    task automatic test_arrival();
        int lat = -1;
        sensor_raw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL arrival cyc %0d: got %h want %h", i, obs(), exp_vec());
            end
            if (c && lat < 0) lat = i;
        end
        checks++;
        if (lat != DEB + 2 || !pend || veh_cnt !== 8'd1) begin
            errors++;
            $display("FAIL arrival_latency: got lat=%0d pend=%b veh=%0d want lat=%0d pend=1 veh=1",
                     lat, pend, veh_cnt, DEB + 2);
        end
    endtask

    task automatic test_service();
        int n_served = 0;
        FG = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) sensor_raw = 1'b0;
            if (i == 15) begin FY = 1'b1; FG = 1'b0; end
            if (i == 20) FY = 1'b0;
            tick();
            if (served) n_served++;
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL service cyc %0d: got %h want %h", i, obs(), exp_vec());
            end
            if (i == 13) begin
                checks++;
                if (c !== 1'b0) begin
                    errors++;
                    $display("FAIL service_early_release: got c=%b want 0", c);
                end
            end
        end
        checks++;
        if (n_served != 1 || c !== 1'b0 || pend !== 1'b0) begin
            errors++;
            $display("FAIL service_end: got served_pulses=%0d c=%b pend=%b want 1 0 0", n_served, c, pend);
        end
    endtask

    task automatic test_leftover();
        sensor_raw = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i == 8) FG = 1'b1;
            if (i == 11) begin FG = 1'b0; FY = 1'b1; end
            if (i == 14) FY = 1'b0;
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL leftover cyc %0d: got %h want %h", i, obs(), exp_vec());
            end
            if (i == 14) begin
                checks++;
                if (c !== 1'b1 || pend !== 1'b1) begin
                    errors++;
                    $display("FAIL leftover_rearm: got c=%b pend=%b want 1 1", c, pend);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        int t = -1;
        sensor_raw = 1'b0; FG = 1'b0; FY = 1'b0;
        do_reset();
        sensor_raw = 1'b1;
        for (int i = 0; i < 20 && !pend; i++) tick();
        checks++;
        if (!pend) begin
            errors++;
            $display("FAIL watchdog_pend: got pend=0 within 20 cycles want 1");
        end
        for (int i = 1; i <= 120; i++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL watchdog cyc %0d: got %h want %h", i, obs(), exp_vec());
            end
            if (stuck && t < 0) t = i;
        end
        checks++;
        if (t != MAXW || c !== 1'b1 || stuck !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_time: got t=%0d c=%b stuck=%b want t=%0d c=1 stuck=1", t, c, stuck, MAXW);
        end
    endtask

    task automatic test_reset_mid_serve();
        FG = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (c !== 1'b1 || pend !== 1'b0) begin
            errors++;
            $display("FAIL serve_entry: got c=%b pend=%b want 1 0", c, pend);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        FG = 1'b0;
        sensor_raw = 1'b0;
        checks++;
        if (obs() !== 20'h0 || exp_vec() !== 20'h0) begin
            errors++;
            $display("FAIL reset_mid_serve: got %h want 00000", obs());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int a = 0; a < 18; a++) begin
            for (int i = 0; i < 12; i++) begin
                sensor_raw = (i < 6);
                tick();
                checks++;
                if (obs() !== exp_vec()) begin
                    errors++;
                    $display("FAIL saturation arr %0d cyc %0d: got %h want %h", a, i, obs(), exp_vec());
                end
            end
        end
        checks++;
        if (veh_cnt4 !== 4'd15 || veh_cnt !== 8'd18) begin
            errors++;
            $display("FAIL saturation_final: got veh4=%0d veh8=%0d want 15 18", veh_cnt4, veh_cnt);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        sensor_raw = 1'b0; FG = 1'b0; FY = 1'b0;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                sensor_raw = ~sensor_raw;
                hold = $urandom_range(1, 8);
            end
            hold--;
            FG = ($urandom_range(0, 3) == 0);
            FY = ($urandom_range(0, 5) == 0);
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs(), exp_vec());
            end
        end
        FG = 1'b0; FY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_arrival();
        test_service();
        test_leftover();
        test_watchdog();
        test_reset_mid_serve();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
